// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes,
// SR/Cause field positions and default vector.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam int SR_IM_LO    = 10;
    localparam int SR_IM_HI    = 15;
    localparam int SR_EXL      = 1;
    localparam int SR_IE       = 0;
    localparam int CAUSE_BD    = 31;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_IP_HI = 15;
    localparam int CAUSE_EC_LO = 2;
    localparam int CAUSE_EC_HI = 6;

    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam logic [31:0] PRID_VAL_DEF   = 32'h2020_0707;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc;
    } cause_t;

    function automatic logic [31:0] sr_word(input sr_t s);
        logic [31:0] w;
        w = '0;
        w[SR_IM_HI:SR_IM_LO] = s.im;
        w[SR_EXL] = s.exl;
        w[SR_IE]  = s.ie;
        return w;
    endfunction

    function automatic logic [31:0] cause_word(input cause_t c);
        logic [31:0] w;
        w = '0;
        w[CAUSE_BD] = c.bd;
        w[CAUSE_IP_HI:CAUSE_IP_LO] = c.ip;
        w[CAUSE_EC_HI:CAUSE_EC_LO] = c.exc;
        return w;
    endfunction

endpackage

// File: rtl/cp0_int_arb.sv
// Interrupt/exception request arbitration and recorded ExcCode.
// Purely combinational; EXL masks both request kinds.
module cp0_int_arb
    import cp0_pkg::*;
(
    input  logic [5:0] hw_int,
    input  logic [5:0] sr_im,
    input  logic       sr_ie,
    input  logic       sr_exl,
    input  logic [4:0] exccode_m,
    output logic       int_req,
    output logic       exc_req,
    output logic       exc_int,
    output logic [4:0] exc_code
);

    always_comb begin
        int_req  = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
        exc_req  = (exccode_m != 5'd0) & ~sr_exl;
        exc_int  = int_req | exc_req;
        exc_code = exccode_m;
        unique case (1'b1)
            int_req: exc_code = EXC_INT;
            exc_req: exc_code = exccode_m;
            default: exc_code = exccode_m;
        endcase
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 register file (SR, Cause, EPC, PRId) and precise-exception
// controller at the M stage; drives the global flush/redirect strobe.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
    parameter logic [31:0] PRID_VAL   = PRID_VAL_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rd_sel,
    input  logic [4:0]  wr_sel,
    input  logic [31:0] wr_data,
    input  logic        we,
    input  logic [4:0]  exccode_m,
    input  logic [31:0] pc_m,
    input  logic [31:0] pc_fallback,
    input  logic        bd_m,
    input  logic        eret_m,
    input  logic [5:0]  hw_int,
    output logic [31:0] rd_data,
    output logic [31:0] epc_out,
    output logic        exc_int,
    output logic [31:0] redirect_pc
);

    sr_t         sr;
    cause_t      cause;
    logic [29:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [4:0]  exc_code;

    logic        bubble;
    logic        bd_eff;
    logic [31:0] vpc;
    logic [31:0] epc_new;
    logic        sr_wr;
    logic        epc_wr;

    cp0_int_arb u_arb (
        .hw_int    (hw_int),
        .sr_im     (sr.im),
        .sr_ie     (sr.ie),
        .sr_exl    (sr.exl),
        .exccode_m (exccode_m),
        .int_req   (int_req),
        .exc_req   (exc_req),
        .exc_int   (exc_int),
        .exc_code  (exc_code)
    );

    // A bubble in M has no delay-slot context of its own.
    always_comb begin
        bubble  = (pc_m == 32'd0);
        vpc     = bubble ? pc_fallback : pc_m;
        bd_eff  = bd_m & ~bubble;
        epc_new = bd_eff ? (vpc - 32'd4) : vpc;
        sr_wr   = we & ~exc_int & (wr_sel == REG_SR);
        epc_wr  = we & ~exc_int & (wr_sel == REG_EPC);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr    <= '0;
            cause <= '0;
            epc   <= '0;
        end else begin
            cause.ip <= hw_int;
            if (exc_int) begin
                sr.exl    <= 1'b1;
                cause.exc <= exc_code;
                cause.bd  <= bd_eff;
                epc       <= epc_new[31:2];
            end else begin
                if (sr_wr) begin
                    sr.im  <= wr_data[SR_IM_HI:SR_IM_LO];
                    sr.exl <= wr_data[SR_EXL];
                    sr.ie  <= wr_data[SR_IE];
                end
                if (eret_m) begin
                    sr.exl <= 1'b0;
                end
                if (epc_wr) begin
                    epc <= wr_data[31:2];
                end
            end
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (rd_sel)
            REG_SR:    rd_data = sr_word(sr);
            REG_CAUSE: rd_data = cause_word(cause);
            REG_EPC:   rd_data = {epc, 2'b00};
            REG_PRID:  rd_data = PRID_VAL;
            default:   rd_data = 32'd0;
        endcase
    end

    assign epc_out     = {epc, 2'b00};
    assign redirect_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed self-checking bench for cp0_exc_ctrl.
// Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
module tb_cp0_exc_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  rd_sel;
    logic [4:0]  wr_sel;
    logic [31:0] wr_data;
    logic        we;
    logic [4:0]  exccode_m;
    logic [31:0] pc_m;
    logic [31:0] pc_fallback;
    logic        bd_m;
    logic        eret_m;
    logic [5:0]  hw_int;
    logic [31:0] rd_data;
    logic [31:0] epc_out;
    logic        exc_int;
    logic [31:0] redirect_pc;

    int n_chk;
    int n_fail;

    cp0_exc_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .rd_sel      (rd_sel),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .we          (we),
        .exccode_m   (exccode_m),
        .pc_m        (pc_m),
        .pc_fallback (pc_fallback),
        .bd_m        (bd_m),
        .eret_m      (eret_m),
        .hw_int      (hw_int),
        .rd_data     (rd_data),
        .epc_out     (epc_out),
        .exc_int     (exc_int),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; wr_sel = 0; wr_data = 0;
        exccode_m = 0; pc_m = 0; pc_fallback = 0;
        bd_m = 0; eret_m = 0; hw_int = 0;
    endtask

    task automatic rd(input logic [4:0] sel, input string tag,
                      input logic [31:0] exp);
        rd_sel = sel;
        #1;
        check(tag, rd_data, exp);
    endtask

    task automatic mtc0(input logic [4:0] sel, input logic [31:0] d);
        we = 1; wr_sel = sel; wr_data = d;
        step();
        we = 0; wr_sel = 0; wr_data = 0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rd_sel = 0;
        idle();
        reset = 1;
        step();
        step();
        reset = 0;
        #1;
        check("rst_exc_int", {31'd0, exc_int}, 32'd0);
        check("rst_epc_out", epc_out, 32'd0);
        check("redirect_pc", redirect_pc, 32'h0000_4180);
        rd(5'd12, "rst_sr", 32'd0);
        rd(5'd13, "rst_cause", 32'd0);
        rd(5'd14, "rst_epc", 32'd0);

        // interrupt taken, M instruction is the victim
        mtc0(5'd12, 32'h0000_0401);
        rd(5'd12, "sr_wr", 32'h0000_0401);
        hw_int = 6'h01; pc_m = 32'h0000_3010;
        #1;
        check("int_exc_int", {31'd0, exc_int}, 32'd1);
        step();
        idle();
        rd(5'd13, "int_cause", 32'h0000_0400);
        rd(5'd12, "int_sr_exl", 32'h0000_0403);
        rd(5'd14, "int_epc", 32'h0000_3010);
        check("int_exl_mask", {31'd0, exc_int}, 32'd0);

        // overflow in a delay slot
        mtc0(5'd12, 32'd0);
        exccode_m = 5'd12; pc_m = 32'h0000_3020; bd_m = 1;
        #1;
        check("ov_exc_int", {31'd0, exc_int}, 32'd1);
        step();
        idle();
        rd(5'd13, "ov_cause", 32'h8000_0030);
        rd(5'd14, "ov_epc", 32'h0000_301C);

        // EXL masks new exceptions; IP keeps tracking lines
        exccode_m = 5'd4; pc_m = 32'h0000_3030; hw_int = 6'h3F;
        #1;
        check("exl_mask", {31'd0, exc_int}, 32'd0);
        step();
        exccode_m = 0; pc_m = 0;
        rd(5'd13, "exl_ip", 32'h8000_FC30);
        rd(5'd14, "exl_epc_hold", 32'h0000_301C);
        eret_m = 1;
        #1;
        check("eret_epc_out", epc_out, 32'h0000_301C);
        step();
        idle();
        rd(5'd12, "eret_exl_clr", 32'd0);

        // bubble in M: fallback PC, BD forced 0
        mtc0(5'd12, 32'h0000_FC01);
        pc_m = 0; pc_fallback = 32'h0000_3044;
        bd_m = 1; hw_int = 6'h20;
        #1;
        check("bub_exc_int", {31'd0, exc_int}, 32'd1);
        step();
        idle();
        rd(5'd14, "bub_epc", 32'h0000_3044);
        rd(5'd13, "bub_cause", 32'h0000_8000);
        rd(5'd12, "bub_sr", 32'h0000_FC03);

        // exception drops a same-cycle mtc0
        mtc0(5'd12, 32'd0);
        we = 1; wr_sel = 5'd14; wr_data = 32'h5555_5557;
        exccode_m = 5'd10; pc_m = 32'h0000_3050;
        #1;
        check("ri_exc_int", {31'd0, exc_int}, 32'd1);
        step();
        idle();
        rd(5'd14, "ri_epc_drop", 32'h0000_3050);
        rd(5'd13, "ri_cause", 32'h0000_0028);
        mtc0(5'd12, 32'd0);
        mtc0(5'd14, 32'h5555_5557);
        rd(5'd14, "epc_wr", 32'h5555_5554);

        // PRId, unmapped select, read-only Cause
        rd(5'd15, "prid", 32'h2020_0707);
        rd(5'd7, "rd_unmapped", 32'd0);
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, "cause_ro", 32'h0000_0028);

        // no write-to-read bypass
        rd_sel = 5'd14;
        we = 1; wr_sel = 5'd14; wr_data = 32'h1234_0000;
        #1;
        check("no_bypass", rd_data, 32'h5555_5554);
        step();
        idle();
        rd(5'd14, "epc_wr2", 32'h1234_0000);

        // exception wins over a same-cycle eret
        eret_m = 1; exccode_m = 5'd5; pc_m = 32'h0000_3060;
        #1;
        check("eret_exc_int", {31'd0, exc_int}, 32'd1);
        step();
        idle();
        rd(5'd12, "eret_lose_sr", 32'h0000_0002);
        rd(5'd13, "eret_lose_cause", 32'h0000_0014);
        rd(5'd14, "eret_lose_epc", 32'h0000_3060);

        // victim PC is word-aligned into EPC
        mtc0(5'd12, 32'd0);
        exccode_m = 5'd4; pc_m = 32'h0000_3073;
        step();
        idle();
        #1;
        check("epc_align", epc_out, 32'h0000_3070);

        // SR write touches only IM/EXL/IE
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, "sr_mask", 32'h0000_FC03);

        // reset beats a simultaneous exception
        mtc0(5'd12, 32'd0);
        exccode_m = 5'd12; pc_m = 32'h0000_3080; hw_int = 6'h3F;
        reset = 1;
        step();
        reset = 0;
        idle();
        rd(5'd12, "rstx_sr", 32'd0);
        rd(5'd13, "rstx_cause", 32'd0);
        rd(5'd14, "rstx_epc", 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 and precise-exception controller; the consuming end of the exception fields carried down the pipeline registers.
- Sits at the M stage. Takes the M-stage exception code, victim PC, branch-delay flag and the six hardware interrupt lines.
- Decides whether to take an exception or interrupt, and drives the global flush/redirect strobe `exc_int` into all pipeline registers and the PC.
- Holds the SR, Cause, EPC and PRId registers for mfc0/mtc0/eret.

Parameters:
- HANDLER_PC, 32'h0000_4180, exception vector driven on `redirect_pc` when `exc_int` is high.
- PRID_VAL, 32'h2020_0707, constant read value of PRId (reg 15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- rd_sel  in  5  mfc0 register number.
- wr_sel  in  5  mtc0 register number.
- wr_data  in  32  mtc0 data.
- we  in  1  mtc0 write enable (M stage).
- exccode_m  in  5  [6:2] exception code of M-stage instruction; 0 means none.
- pc_m  in  32  PC of M-stage instruction; 0 means bubble.
- pc_fallback  in  32  PC of the oldest valid younger instruction; used when pc_m is 0.
- bd_m  in  1  M-stage instruction is in a delay slot.
- eret_m  in  1  eret is in M.
- hw_int  in  6  [7:2] external interrupt lines, level sensitive.
- rd_data  out  32  mfc0 read data.
- epc_out  out  32  current EPC, for eret redirect.
- exc_int  out  1  take exception now: flush all pipeline registers and redirect PC.
- redirect_pc  out  32  HANDLER_PC.

Behaviour:
- Register fields:
  - SR: IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause: BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC: bits [31:2]; bits [1:0] read 0.
- Reset: SR=0, Cause=0, EPC=0.
  - Outputs after reset: exc_int=0, epc_out=0, rd_data follows rd_sel.
- Combinational request terms:
  - int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
  - exc_req = (exccode_m != 0) & ~SR.EXL.
  - exc_int = int_req | exc_req, same cycle, no register stage.
- Priority: interrupt over exception. On int_req the recorded ExcCode is 0 (Int) and the M instruction is the victim.
- Victim PC vpc = (pc_m != 0) ? pc_m : pc_fallback.
- On a clock edge with exc_int=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= int_req ? 0 : exccode_m.
  - Cause.BD <= bd_m.
  - EPC <= bd_m ? vpc-4 : vpc, word-aligned.
- If pc_m=0, BD is taken as 0 regardless of bd_m.
- exc_int blocks mtc0: a write to SR, Cause or EPC in the same cycle is dropped.
- eret_m with exc_int=0: SR.EXL <= 0 on the edge.
  - epc_out is valid combinationally for the PC redirect.
  - The eret-vs-interrupt conflict cannot arise (EXL=1 masks int_req), but the design must not depend on that: exc_int wins.
- mtc0 (we=1, exc_int=0):
  - wr_sel 12 writes IM and EXL/IE fields only.
  - wr_sel 14 writes EPC[31:2].
  - wr_sel 13: Cause is read-only, write ignored.
  - wr_sel 15 and others: write ignored.
- Cause.IP <= hw_int every cycle, unconditionally, including while EXL=1.
- mfc0 read is combinational:
  - Select 12, 13, 14, 15; any other select returns 0.
  - Same-cycle mtc0 to the same register does NOT bypass; old value is read.
- Reset mid-exception (reset and exc_int together): reset wins, all state cleared.

Decomposition:
- Shared package `cp0_pkg`:
  - Register numbers: SR=12, CAUSE=13, EPC=14, PRID=15.
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12.
  - SR/Cause field bit positions.
  - HANDLER_PC default.
- One sub-module, `cp0_int_arb`:
  - Combinational int_req/exc_req/priority and recorded-ExcCode selection.
  - Unit-testable alone.
- Register file and update logic stay in the top.

Test Plan:
- reset, then mtc0 SR=32'h0000_0401 (IM[10], IE) and raise hw_int[2] → same cycle exc_int=1. Next cycle: Cause=32'h0000_0400, ExcCode=0, EXL=1; EPC=pc_m=0x0000_3010.
- exccode_m=12 (Ov), pc_m=0x3020, bd_m=1, SR=0 → exc_int=1. Then Cause=32'h8000_0030, EPC=0x301C.
- EXL=1, exccode_m=4 and hw_int=6'h3F → exc_int=0, Cause.IP=6'h3F, EPC unchanged. Then eret_m=1 → EXL cleared next cycle, epc_out=EPC.
- pc_m=0 bubble, pc_fallback=0x3044, interrupt enabled and pending → EPC=0x3044, BD=0.
- we=1, wr_sel=14, wr_data=0x5555_5557 in the same cycle exccode_m=10, pc_m=0x3050 → EPC=0x3050 (write dropped). Without the exception, EPC reads 0x5555_5554.
- mfc0 rd_sel=15 → PRID_VAL; rd_sel=7 → 0. mtc0 to Cause 0xFFFF_FFFF → Cause unchanged.
